// File: rtl/ring_pkg.sv
// Shared ring constants: flit geometry, rep control codes and the upload FSM encoding.
// The download assembler imports the same package so both ends agree on framing.
package ring_pkg;

  localparam int FLIT_W     = 16;
  localparam int DATA_FLITS = 8;
  localparam int CNT_W      = 3;
  localparam int LINE_W     = FLIT_W * DATA_FLITS;

  localparam logic [1:0] CTRL_IDLE = 2'b00;
  localparam logic [1:0] CTRL_HEAD = 2'b01;
  localparam logic [1:0] CTRL_BODY = 2'b10;
  localparam logic [1:0] CTRL_TAIL = 2'b11;

  // Encoding 2'b11 is unused and treated as IDLE by the upload FSM.
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_HEAD = 2'b01;
  localparam logic [1:0] ST_BODY = 2'b10;

endpackage

// File: rtl/m_rep_upload_flit_mux.sv
// Combinational slice select: picks flit number sel out of a cache line, slice 0 = bits [15:0].
module m_rep_upload_flit_mux
  import ring_pkg::*;
(
  input  logic [LINE_W-1:0] line,
  input  logic [CNT_W-1:0]  sel,
  output logic [FLIT_W-1:0] flit
);

  assign flit = line[FLIT_W*int'(sel) +: FLIT_W];

endmodule

// File: rtl/m_rep_upload.sv
// Memory-side reply uploader: latches one header (+ optional cache line) and serialises it
// into 16-bit rep flits with ctrl codes for the OUT_rep FIFO.
module m_rep_upload
  import ring_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              v_m_rep,
  input  logic [FLIT_W-1:0] m_rep_head,
  input  logic              m_rep_has_data,
  input  logic [LINE_W-1:0] m_rep_data,
  input  logic              rep_fifo_full,
  output logic              m_rep_ack,
  output logic [FLIT_W-1:0] rep_flit,
  output logic              v_rep_flit,
  output logic [1:0]        rep_ctrl,
  output logic [1:0]        m_rep_upload_state
);

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [FLIT_W-1:0] head_reg;
  logic [LINE_W-1:0] data_reg;
  logic              has_data_reg;
  logic [FLIT_W-1:0] body_flit;
  logic              is_idle;
  logic              last_flit;

  assign is_idle   = (state != ST_HEAD) && (state != ST_BODY);
  assign last_flit = (cnt == CNT_W'(DATA_FLITS - 1));

  // Ack is withheld during reset so a handshake can never be lost to a clearing register.
  assign m_rep_ack          = is_idle && v_m_rep && !rst;
  assign m_rep_upload_state = state;

  m_rep_upload_flit_mux u_flit_mux (
    .line (data_reg),
    .sel  (cnt),
    .flit (body_flit)
  );

  always_comb begin
    rep_flit   = '0;
    rep_ctrl   = CTRL_IDLE;
    v_rep_flit = 1'b0;
    if (state == ST_HEAD) begin
      rep_flit   = head_reg;
      rep_ctrl   = has_data_reg ? CTRL_HEAD : CTRL_TAIL;
      v_rep_flit = !rep_fifo_full;
    end else if (state == ST_BODY) begin
      rep_flit   = body_flit;
      rep_ctrl   = last_flit ? CTRL_TAIL : CTRL_BODY;
      v_rep_flit = !rep_fifo_full;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      head_reg     <= '0;
      data_reg     <= '0;
      has_data_reg <= 1'b0;
    end else if (is_idle) begin
      cnt <= '0;
      if (v_m_rep) begin
        head_reg     <= m_rep_head;
        data_reg     <= m_rep_data;
        has_data_reg <= m_rep_has_data;
        state        <= ST_HEAD;
      end else begin
        state <= ST_IDLE;
      end
    end else if (state == ST_HEAD) begin
      if (v_rep_flit) begin
        state <= has_data_reg ? ST_BODY : ST_IDLE;
        cnt   <= '0;
      end
    end else begin
      if (v_rep_flit) begin
        if (last_flit) begin
          state <= ST_IDLE;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_m_rep_upload.sv
// Bench for m_rep_upload: cycle table, hand-written corner sequences, and a random
// backpressure run checked by a message-level download-assembler model.
module tb_m_rep_upload;
  import ring_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              v_m_rep;
  logic [FLIT_W-1:0] m_rep_head;
  logic              m_rep_has_data;
  logic [LINE_W-1:0] m_rep_data;
  logic              rep_fifo_full;
  logic              m_rep_ack;
  logic [FLIT_W-1:0] rep_flit;
  logic              v_rep_flit;
  logic [1:0]        rep_ctrl;
  logic [1:0]        m_rep_upload_state;

  m_rep_upload dut (
    .clk                (clk),
    .rst                (rst),
    .v_m_rep            (v_m_rep),
    .m_rep_head         (m_rep_head),
    .m_rep_has_data     (m_rep_has_data),
    .m_rep_data         (m_rep_data),
    .rep_fifo_full      (rep_fifo_full),
    .m_rep_ack          (m_rep_ack),
    .rep_flit           (rep_flit),
    .v_rep_flit         (v_rep_flit),
    .rep_ctrl           (rep_ctrl),
    .m_rep_upload_state (m_rep_upload_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic        has;
    logic [15:0] head;
    logic        full;
    logic        ack;
    logic        vf;
    logic [1:0]  ctrl;
    logic [15:0] flit;
    logic [1:0]  st;
  } vec_t;

  typedef struct {
    logic [15:0]  head;
    logic         has;
    logic [127:0] line;
  } msg_t;

  localparam logic [127:0] LINE0 = 128'h0007_0006_0005_0004_0003_0002_0001_0000;
  localparam logic [127:0] LINEA = 128'h1117_1116_1115_1114_1113_1112_1111_1110;
  localparam logic [127:0] LINEB = 128'h2227_2226_2225_2224_2223_2222_2221_2220;

  int errors = 0;
  int checks = 0;
  vec_t tbl[14];
  logic [17:0] got[$];
  logic [17:0] exp_seq[$];
  msg_t exp_q[$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic settle();
    #1;
    if (v_rep_flit === 1'b1) got.push_back({rep_ctrl, rep_flit});
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic set_msg(input logic v, input logic has, input logic [15:0] h, input logic [127:0] d);
    v_m_rep        = v;
    m_rep_has_data = has;
    m_rep_head     = h;
    m_rep_data     = d;
  endtask

  // Expected flit stream for one message: {ctrl, flit}.
  task automatic add_seq(input logic has, input logic [15:0] h, input logic [127:0] d);
    if (!has) begin
      exp_seq.push_back({CTRL_TAIL, h});
    end else begin
      exp_seq.push_back({CTRL_HEAD, h});
      for (int k = 0; k < 8; k++)
        exp_seq.push_back({(k == 7) ? CTRL_TAIL : CTRL_BODY, d[16*k +: 16]});
    end
  endtask

  task automatic cmp_stream(input string nm);
    chk({nm, "_count"}, 128'(got.size()), 128'(exp_seq.size()));
    for (int i = 0; i < exp_seq.size(); i++) begin
      if (i < got.size()) chk($sformatf("%s_flit%0d", nm, i), 128'(got[i]), 128'(exp_seq[i]));
    end
  endtask

  function automatic vec_t mk(input logic v, input logic has, input logic [15:0] h,
                              input logic ack, input logic vf, input logic [1:0] c,
                              input logic [15:0] f, input logic [1:0] s);
    vec_t r;
    r.v = v; r.has = has; r.head = h; r.full = 1'b0;
    r.ack = ack; r.vf = vf; r.ctrl = c; r.flit = f; r.st = s;
    return r;
  endfunction

  // Random-run state
  logic        pending;
  int          sent, done_msgs;
  logic        asm_busy;
  int          asm_idx;
  logic [15:0] asm_head;
  logic [127:0] asm_line;
  logic        prev_full;
  logic [1:0]  prev_st, prev_ctrl;
  logic [15:0] prev_flit;
  msg_t        m, e;

  task automatic finish_msg(input logic has);
    if (exp_q.size() == 0) begin
      chk("asm_unexpected_msg", 1, 0);
    end else begin
      e = exp_q.pop_front();
      chk("asm_head", 128'(asm_head), 128'(e.head));
      chk("asm_has_data", 128'(has), 128'(e.has));
      if (has && e.has) chk("asm_line", asm_line, e.line);
    end
    done_msgs++;
  endtask

  initial begin
    rst = 1'b1;
    rep_fifo_full = 1'b0;
    set_msg(1'b0, 1'b0, 16'h0, '0);
    adv();
    adv();
    rst = 1'b0;
    settle();
    chk("rst_state", 128'(m_rep_upload_state), 128'(ST_IDLE));
    chk("rst_vf", 128'(v_rep_flit), 0);
    chk("rst_ctrl", 128'(rep_ctrl), 128'(CTRL_IDLE));
    chk("rst_flit", 128'(rep_flit), 0);
    chk("rst_ack", 128'(m_rep_ack), 0);

    // Cycle table: full line then header-only, FIFO never full.
    tbl[0] = mk(1, 1, 16'hA5C3, 1, 0, CTRL_IDLE, 16'h0, ST_IDLE);
    tbl[1] = mk(0, 0, 16'hDEAD, 0, 1, CTRL_HEAD, 16'hA5C3, ST_HEAD);
    for (int k = 0; k < 7; k++) tbl[2+k] = mk(0, 0, 16'hDEAD, 0, 1, CTRL_BODY, 16'(k), ST_BODY);
    tbl[9]  = mk(0, 0, 16'hDEAD, 0, 1, CTRL_TAIL, 16'h0007, ST_BODY);
    tbl[10] = mk(0, 0, 16'hDEAD, 0, 0, CTRL_IDLE, 16'h0, ST_IDLE);
    tbl[11] = mk(1, 0, 16'h1234, 1, 0, CTRL_IDLE, 16'h0, ST_IDLE);
    tbl[12] = mk(0, 1, 16'hDEAD, 0, 1, CTRL_TAIL, 16'h1234, ST_HEAD);
    tbl[13] = mk(0, 0, 16'hDEAD, 0, 0, CTRL_IDLE, 16'h0, ST_IDLE);
    for (int i = 0; i < 14; i++) begin
      set_msg(tbl[i].v, tbl[i].has, tbl[i].head, (i < 11) ? LINE0 : ~LINE0);
      rep_fifo_full = tbl[i].full;
      settle();
      chk($sformatf("tbl%0d_ack", i), 128'(m_rep_ack), 128'(tbl[i].ack));
      chk($sformatf("tbl%0d_vf", i), 128'(v_rep_flit), 128'(tbl[i].vf));
      chk($sformatf("tbl%0d_ctrl", i), 128'(rep_ctrl), 128'(tbl[i].ctrl));
      chk($sformatf("tbl%0d_flit", i), 128'(rep_flit), 128'(tbl[i].flit));
      chk($sformatf("tbl%0d_state", i), 128'(m_rep_upload_state), 128'(tbl[i].st));
      adv();
    end

    // Backpressure for 3 cycles at cnt=3.
    got.delete(); exp_seq.delete();
    set_msg(1, 1, 16'hA5C3, LINE0);
    settle(); chk("bp_ack", 128'(m_rep_ack), 1); adv();
    set_msg(0, 0, 16'hDEAD, '1);
    repeat (4) begin settle(); adv(); end
    rep_fifo_full = 1'b1;
    repeat (3) begin
      settle();
      chk("bp_vf", 128'(v_rep_flit), 0);
      chk("bp_flit", 128'(rep_flit), 128'h0003);
      chk("bp_ctrl", 128'(rep_ctrl), 128'(CTRL_BODY));
      chk("bp_state", 128'(m_rep_upload_state), 128'(ST_BODY));
      adv();
    end
    rep_fifo_full = 1'b0;
    repeat (5) begin settle(); adv(); end
    settle();
    chk("bp_end_state", 128'(m_rep_upload_state), 128'(ST_IDLE));
    add_seq(1, 16'hA5C3, LINE0);
    cmp_stream("bp");

    // Request held high while busy.
    got.delete(); exp_seq.delete();
    set_msg(1, 1, 16'hC0DE, LINEA);
    settle(); chk("busy_ackA", 128'(m_rep_ack), 1); adv();
    set_msg(1, 1, 16'hBEEF, LINEB);
    for (int i = 1; i <= 9; i++) begin
      settle(); chk($sformatf("busy_noack_t%0d", i), 128'(m_rep_ack), 0); adv();
    end
    settle();
    chk("busy_ackB", 128'(m_rep_ack), 1);
    chk("busy_idle_t10", 128'(m_rep_upload_state), 128'(ST_IDLE));
    adv();
    set_msg(0, 0, 16'h5555, ~LINEB);
    settle();
    chk("busy_headB", 128'(rep_flit), 128'h0BEEF);
    chk("busy_ctrlB", 128'(rep_ctrl), 128'(CTRL_HEAD));
    adv();
    repeat (8) begin settle(); adv(); end
    settle();
    chk("busy_end_state", 128'(m_rep_upload_state), 128'(ST_IDLE));
    add_seq(1, 16'hC0DE, LINEA);
    add_seq(1, 16'hBEEF, LINEB);
    cmp_stream("busy");

    // Reset at cnt=4, then a fresh header-only message.
    set_msg(1, 1, 16'h7777, LINE0);
    settle(); adv();
    set_msg(0, 0, 16'h0, '0);
    repeat (5) begin settle(); adv(); end
    settle();
    chk("rmid_flit_cnt4", 128'(rep_flit), 128'h0004);
    rst = 1'b1;
    adv();
    rst = 1'b0;
    settle();
    chk("rmid_vf", 128'(v_rep_flit), 0);
    chk("rmid_ctrl", 128'(rep_ctrl), 128'(CTRL_IDLE));
    chk("rmid_state", 128'(m_rep_upload_state), 128'(ST_IDLE));
    chk("rmid_flit", 128'(rep_flit), 0);
    set_msg(1, 0, 16'h0BEE, LINE0);
    settle(); chk("rmid_ack", 128'(m_rep_ack), 1); adv();
    set_msg(0, 0, 16'h0, '0);
    settle();
    chk("rmid_new_flit", 128'(rep_flit), 128'h0BEE);
    chk("rmid_new_ctrl", 128'(rep_ctrl), 128'(CTRL_TAIL));
    chk("rmid_new_vf", 128'(v_rep_flit), 1);
    adv();
    settle();
    chk("rmid_new_idle", 128'(m_rep_upload_state), 128'(ST_IDLE));

    // Random messages under random FIFO-full, reassembled by a download-assembler model.
    pending = 0; sent = 0; done_msgs = 0; asm_busy = 0; asm_idx = 0;
    asm_head = '0; asm_line = '0; prev_full = 0; prev_st = ST_IDLE; prev_ctrl = '0; prev_flit = '0;
    exp_q.delete();
    for (int cyc = 0; cyc < 20000 && done_msgs < 100; cyc++) begin
      if (!pending) begin
        set_msg(0, 1'($urandom), 16'($urandom), {$urandom, $urandom, $urandom, $urandom});
        if (sent < 100 && $urandom_range(0, 3) != 0) begin
          m.head = 16'($urandom);
          m.has  = ($urandom_range(0, 4) != 0);
          m.line = {$urandom, $urandom, $urandom, $urandom};
          set_msg(1, m.has, m.head, m.line);
          pending = 1;
        end
      end
      rep_fifo_full = ($urandom_range(0, 2) == 0);
      #1;
      if (m_rep_ack) begin
        exp_q.push_back(m);
        pending = 0;
        sent++;
      end
      if (rep_fifo_full) chk("rnd_full_no_push", 128'(v_rep_flit), 0);
      if (prev_full && prev_st != ST_IDLE) begin
        chk("rnd_stall_flit", 128'(rep_flit), 128'(prev_flit));
        chk("rnd_stall_ctrl", 128'(rep_ctrl), 128'(prev_ctrl));
      end
      if (v_rep_flit) begin
        if (!asm_busy) begin
          if (rep_ctrl == CTRL_HEAD) begin
            asm_head = rep_flit; asm_busy = 1; asm_idx = 0;
          end else begin
            chk("asm_head_ctrl", 128'(rep_ctrl), 128'(CTRL_TAIL));
            asm_head = rep_flit;
            finish_msg(1'b0);
          end
        end else begin
          chk("asm_body_ctrl", 128'(rep_ctrl), 128'((asm_idx == 7) ? CTRL_TAIL : CTRL_BODY));
          asm_line[16*asm_idx +: 16] = rep_flit;
          asm_idx++;
          if (asm_idx == 8) begin
            asm_busy = 0;
            finish_msg(1'b1);
          end
        end
      end
      prev_full = rep_fifo_full;
      prev_st   = m_rep_upload_state;
      prev_ctrl = rep_ctrl;
      prev_flit = rep_flit;
      @(posedge clk);
      #1;
    end
    chk("rnd_msgs_done", 128'(done_msgs), 100);
    chk("rnd_queue_empty", 128'(exp_q.size()), 0);
    chk("rnd_asm_idle", 128'(asm_busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/m_rep_upload.md
Name: m_rep_upload

Overview:
- Upstream neighbour of the instruction-cache download stage, on the memory side.
- Takes one reply message from the local memory controller: a 16-bit header plus an optional 128-bit cache line.
- Serialises it into 16-bit rep flits with 2-bit control codes and pushes them into the OUT_rep FIFO toward the ring.
- Its flit order and ctrl codes are exactly what the downstream assembler consumes: data slice [15:0] first, tail on [127:112].

Parameters:
- FLIT_W, 16, flit width in bits.
- DATA_FLITS, 8, data flits per cache line; line width = FLIT_W*DATA_FLITS.
- CNT_W, 3, width of the data-flit counter; log2(DATA_FLITS).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- v_m_rep  in  1  memory has a reply pending; held high until m_rep_ack.
- m_rep_head  in  16  header flit (dest/src/type), latched at accept.
- m_rep_has_data  in  1  1 = header + 8 data flits; 0 = header-only message.
- m_rep_data  in  128  cache line, latched at accept.
- rep_fifo_full  in  1  OUT_rep FIFO full; no push when high.
- m_rep_ack  out  1  one-cycle pulse: message latched, inputs may change next cycle.
- rep_flit  out  16  flit to FIFO.
- v_rep_flit  out  1  FIFO push strobe; a flit counts as sent iff v_rep_flit=1.
- rep_ctrl  out  2  01 = head, 10 = body, 11 = tail or head-only, 00 = idle.
- m_rep_upload_state  out  2  current FSM state, for debug and arbitration.

Behaviour:
- Encodings: IDLE = 00, HEAD = 01, BODY = 10; 11 unused and decodes to IDLE.
- Reset (sync, rst=1 at posedge), next cycle:
  - state = IDLE, cnt = 0.
  - head/data/has_data registers cleared.
  - m_rep_ack = 0, v_rep_flit = 0, rep_ctrl = 00, rep_flit = 0.
- Reset mid-message: message aborted and discarded, no further flits. Downstream recovers via its own reset.
- IDLE:
  - v_m_rep=1 → latch head, data and has_data; m_rep_ack=1 combinationally in that cycle; next state HEAD.
  - v_rep_flit=0 in IDLE. No ack is given in any state other than IDLE.
- HEAD:
  - rep_flit = head_reg.
  - rep_ctrl = 01 if has_data_reg, else 11.
  - v_rep_flit = !rep_fifo_full.
  - On push: has_data_reg → BODY with cnt = 0; else → IDLE.
- BODY:
  - rep_flit = data_reg[16*cnt+15 : 16*cnt].
  - rep_ctrl = 10 while cnt < DATA_FLITS-1; 11 when cnt = DATA_FLITS-1.
  - v_rep_flit = !rep_fifo_full.
  - On push: cnt increments; push at cnt = DATA_FLITS-1 → IDLE with cnt = 0. cnt never wraps inside a message.
- Stall: while rep_fifo_full=1, state, cnt, rep_flit and rep_ctrl hold stable; v_rep_flit=0. A full→not-full change in the same cycle pushes immediately.
- Outputs: rep_flit, rep_ctrl and v_rep_flit are combinational from registered state, with no dependence on v_m_rep.
- Latency:
  - accept cycle T (ack) → head flit earliest at T+1.
  - full line = 9 push cycles (T+1..T+9), back-to-back with no stall.
  - next accept earliest T+10 (one IDLE cycle between messages).
- Simultaneous events:
  - v_m_rep while HEAD/BODY: ignored, no ack, latched message untouched.
  - m_rep_data changing after ack: no effect.
- Throughput: ≤1 flit per cycle; no flit is dropped or duplicated under any full pattern.

Decomposition:
- Shared package (ring_pkg): FLIT_W, DATA_FLITS, ctrl codes (CTRL_IDLE 00, CTRL_HEAD 01, CTRL_BODY 10, CTRL_TAIL 11), FSM state encodings. The same package is used by the download assembler so both ends agree.
- Optional sub-module flit_mux: a combinational 128→16 slice select by cnt. The FSM, counter and registers stay in m_rep_upload.

Test Plan:
- Reset, then single line, FIFO never full: head=16'hA5C3, data=128'h0007_0006_0005_0004_0003_0002_0001_0000 → ack at T; T+1 flit A5C3/ctrl 01; T+2..T+8 flits 0000..0006/ctrl 10; T+9 flit 0007/ctrl 11; state IDLE at T+10.
- Header-only: has_data=0, head=16'h1234 → single flit 1234/ctrl 11 at T+1; idle at T+2; no data flits.
- Backpressure: rep_fifo_full high for 3 cycles while cnt=3 → v_rep_flit=0 and rep_flit=0003 held stable; after release, flits 0003..0007 follow; total pushes exactly 9; ctrl sequence unchanged.
- Request while busy: v_m_rep held high with a second message during BODY → no ack until IDLE; second message ack at T+10; its head appears at T+11; first message intact.
- Reset at cnt=4: rst one cycle → next cycle v_rep_flit=0, rep_ctrl=00, state IDLE; a new request then starts from the head flit.
- Random full pattern over 100 messages: scoreboard reassembles lines through a model of the download assembler; every word matches and ctrl sequence is 01,10×7,11 per message.
